sonata_sw_debounce: RTL and testbench

//  Conditions the Sonata board's raw switch inputs before they reach the demo system GPIO input

---
 rtl/sonata_sw_debounce.sv | 65 ++++++
 tb/tb_sonata_sw_debounce.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sonata_sw_debounce.sv
// Switch conditioner: 2-flop sync, polarity normalise, per-bit debounce, rise/fall pulses.
// Latency 2 + DebounceCycles clk_sys edges raw->sw_o; free-running, no backpressure.
module sonata_sw_debounce #(
  parameter int unsigned Width          = 13,
  parameter int unsigned DebounceCycles = 500000,
  parameter bit          ActiveLow      = 1'b1
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] sw_raw_i,
  output logic [Width-1:0] sw_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             changed_o
);

  localparam int unsigned     CntW    = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [Width-1:0] sw_norm;
  logic [Width-1:0] sync_q1;
  logic [Width-1:0] sync_q2;
  logic [Width-1:0] accept;
  logic [CntW-1:0]  cnt_q [Width];

  // Normalised domain: 0 is always "off", so reset loads zeros into the synchroniser.
  assign sw_norm = ActiveLow ? ~sw_raw_i : sw_raw_i;

  always_comb begin
    accept = '0;
    for (int i = 0; i < Width; i++) begin
      accept[i] = (sync_q2[i] != sw_o[i]) && (cnt_q[i] == CntLast);
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      sync_q1   <= '0;
      sync_q2   <= '0;
      sw_o      <= '0;
      rise_o    <= '0;
      fall_o    <= '0;
      changed_o <= 1'b0;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_q1   <= sw_norm;
      sync_q2   <= sync_q1;
      sw_o      <= sw_o ^ accept;
      rise_o    <= accept & sync_q2;
      fall_o    <= accept & ~sync_q2;
      changed_o <= |accept;
      // Any agreeing sample restarts the run; accept also clears so the count never wraps.
      for (int i = 0; i < Width; i++) begin
        if ((sync_q2[i] == sw_o[i]) || accept[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sonata_sw_debounce.sv
// Directed bench for sonata_sw_debounce with Width=4, DebounceCycles=4, ActiveLow=1.
module tb_sonata_sw_debounce;

  logic       clk_sys_i = 1'b0;
  logic       rst_sys_i = 1'b1;
  logic [3:0] sw_raw_i  = 4'hF;
  logic [3:0] sw_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;
  logic       changed_o;

  int n_tests = 0;
  int n_fail  = 0;

  sonata_sw_debounce #(
    .Width         (4),
    .DebounceCycles(4),
    .ActiveLow     (1'b1)
  ) dut (
    .clk_sys_i(clk_sys_i),
    .rst_sys_i(rst_sys_i),
    .sw_raw_i (sw_raw_i),
    .sw_o     (sw_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .changed_o(changed_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk_sys_i);
    #1;
  endtask

  // Release all switches and let the filter settle back to all-off.
  task automatic restore();
    sw_raw_i = 4'hF;
    repeat (10) tick();
    check("restore_sw", {28'd0, sw_o}, 32'h0);
  endtask

  initial begin
    // 1: reset held with all switches off
    rst_sys_i = 1'b1;
    sw_raw_i  = 4'hF;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("rst_sw", {28'd0, sw_o}, 32'h0);
      check("rst_pulse", {24'd0, rise_o, fall_o}, 32'h0);
      check("rst_changed", {31'd0, changed_o}, 32'h0);
    end
    rst_sys_i = 1'b0;
    repeat (4) tick();
    check("post_rst_sw", {28'd0, sw_o}, 32'h0);

    // 2: bit0 pressed after edge N, accepted at N+6
    sw_raw_i = 4'b1110;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("b0_sw", {31'd0, sw_o[0]}, (k >= 6) ? 32'd1 : 32'd0);
      check("b0_rise", {28'd0, rise_o}, (k == 6) ? 32'h1 : 32'h0);
      check("b0_fall", {28'd0, fall_o}, 32'h0);
      check("b0_changed", {31'd0, changed_o}, (k == 6) ? 32'd1 : 32'd0);
    end
    restore();

    // 3: 3-cycle glitch on bit1 is rejected
    sw_raw_i = 4'b1101;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) sw_raw_i = 4'b1111;
      check("glitch_sw", {28'd0, sw_o}, 32'h0);
      check("glitch_changed", {31'd0, changed_o}, 32'd0);
    end

    // 4: bit2 chatters every 2 cycles, then held pressed from edge M
    for (int c = 0; c < 12; c++) begin
      sw_raw_i[2] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      check("chat_sw", {28'd0, sw_o}, 32'h0);
      check("chat_changed", {31'd0, changed_o}, 32'd0);
    end
    sw_raw_i[2] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("chat_rise", {28'd0, rise_o}, (k == 6) ? 32'h4 : 32'h0);
      check("chat_sw_held", {31'd0, sw_o[2]}, (k >= 6) ? 32'd1 : 32'd0);
    end
    restore();

    // 5: bit0 and bit3 pressed together, bit0 released 20 cycles later
    sw_raw_i = 4'b0110;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("pair_rise", {28'd0, rise_o}, (k == 6) ? 32'h9 : 32'h0);
      check("pair_fall", {28'd0, fall_o}, 32'h0);
    end
    check("pair_sw_on", {28'd0, sw_o}, 32'h9);
    sw_raw_i = 4'b0111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("pair_rel_fall", {28'd0, fall_o}, (k == 6) ? 32'h1 : 32'h0);
      check("pair_rel_rise", {28'd0, rise_o}, 32'h0);
    end
    check("pair_sw_after", {28'd0, sw_o}, 32'h8);
    restore();

    // 6: reset mid-count on bit1; re-accepted 6 cycles after release
    sw_raw_i = 4'b1101;
    repeat (4) tick();
    rst_sys_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("midrst_sw", {28'd0, sw_o}, 32'h0);
      check("midrst_pulse", {24'd0, rise_o, fall_o}, 32'h0);
    end
    rst_sys_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("midrst_rise", {28'd0, rise_o}, (k == 6) ? 32'h2 : 32'h0);
      check("midrst_sw_after", {31'd0, sw_o[1]}, (k >= 6) ? 32'd1 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
